// File: rtl/decode_stage_pkg.sv
// Shared Y86 decode definitions: instruction codes, register constants,
// datapath widths and the E pipeline register layout with its NOP bubble.
package decode_stage_pkg;

  localparam int DATA_WID = 32;
  localparam int ADDR_WID = 4;

  localparam logic [ADDR_WID-1:0] RNONE = 4'hF;
  localparam logic [ADDR_WID-1:0] RESP  = 4'h4;

  typedef enum logic [3:0] {
    ICODE_HALT   = 4'h0,
    ICODE_NOP    = 4'h1,
    ICODE_RRMOVL = 4'h2,
    ICODE_IRMOVL = 4'h3,
    ICODE_RMMOVL = 4'h4,
    ICODE_MRMOVL = 4'h5,
    ICODE_OPL    = 4'h6,
    ICODE_JXX    = 4'h7,
    ICODE_CALL   = 4'h8,
    ICODE_RET    = 4'h9,
    ICODE_PUSHL  = 4'hA,
    ICODE_POPL   = 4'hB
  } icode_e;

  typedef struct packed {
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [DATA_WID-1:0] valC;
    logic [DATA_WID-1:0] valA;
    logic [DATA_WID-1:0] valB;
    logic [ADDR_WID-1:0] dstE;
    logic [ADDR_WID-1:0] dstM;
    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
  } e_reg_t;

  localparam e_reg_t NOP_BUBBLE = '{
    icode: ICODE_NOP, ifun: 4'h0,
    valC: '0, valA: '0, valB: '0,
    dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
  };

endpackage

// File: rtl/decode_stage_fwd_mux.sv
// Five-source priority forwarding selector; index 0 has the highest priority.
// A register address of RNONE never matches.
module fwd_mux
  import decode_stage_pkg::*;
(
  input  logic [ADDR_WID-1:0]           src,
  input  logic [DATA_WID-1:0]           rf_val,
  input  logic [4:0][ADDR_WID-1:0]      dst,
  input  logic [4:0][DATA_WID-1:0]      val,
  output logic [DATA_WID-1:0]           val_out,
  output logic                          hit
);

  // Walk from lowest to highest priority so the highest match is applied last.
  always_comb begin
    val_out = rf_val;
    hit     = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (src != RNONE && dst[i] == src) begin
        val_out = val[i];
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Y86 pipeline decode stage with operand forwarding, E register and hazard flag.
// Optional feature macro: DECODE_FORWARD_EN (forwarding muxes, load-use-only hazard).
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          D_icode,
  input  logic [3:0]          D_ifun,
  input  logic [ADDR_WID-1:0] D_rA,
  input  logic [ADDR_WID-1:0] D_rB,
  input  logic [DATA_WID-1:0] D_valC,
  input  logic [DATA_WID-1:0] D_valP,
  output logic [ADDR_WID-1:0] srcA,
  output logic [ADDR_WID-1:0] srcB,
  input  logic [DATA_WID-1:0] rf_valA,
  input  logic [DATA_WID-1:0] rf_valB,
  input  logic [ADDR_WID-1:0] e_dstE,
  input  logic [DATA_WID-1:0] e_valE,
  input  logic [ADDR_WID-1:0] M_dstM,
  input  logic [DATA_WID-1:0] m_valM,
  input  logic [ADDR_WID-1:0] M_dstE,
  input  logic [DATA_WID-1:0] M_valE,
  input  logic [ADDR_WID-1:0] W_dstM,
  input  logic [DATA_WID-1:0] W_valM,
  input  logic [ADDR_WID-1:0] W_dstE,
  input  logic [DATA_WID-1:0] W_valE,
  input  logic                E_stall,
  input  logic                E_bubble,
  output logic [3:0]          E_icode,
  output logic [3:0]          E_ifun,
  output logic [DATA_WID-1:0] E_valC,
  output logic [DATA_WID-1:0] E_valA,
  output logic [DATA_WID-1:0] E_valB,
  output logic [ADDR_WID-1:0] E_dstE,
  output logic [ADDR_WID-1:0] E_dstM,
  output logic [ADDR_WID-1:0] E_srcA,
  output logic [ADDR_WID-1:0] E_srcB,
  output logic                hazard
);

`ifdef DECODE_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [ADDR_WID-1:0]      dstE, dstM;
  logic [4:0][ADDR_WID-1:0] fwd_dst;
  logic [4:0][DATA_WID-1:0] fwd_val;
  logic [DATA_WID-1:0]      fwd_valA, fwd_valB, d_valA, d_valB;
  logic                     hit_a, hit_b, load_use, e_dstm_hit;
  e_reg_t                   e_reg, e_next;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode_e'(D_icode))
      ICODE_RRMOVL: begin srcA = D_rA; dstE = D_rB; end
      ICODE_IRMOVL: dstE = D_rB;
      ICODE_RMMOVL: begin srcA = D_rA; srcB = D_rB; end
      ICODE_MRMOVL: begin srcB = D_rB; dstM = D_rA; end
      ICODE_OPL:    begin srcA = D_rA; srcB = D_rB; dstE = D_rB; end
      ICODE_CALL:   begin srcB = RESP; dstE = RESP; end
      ICODE_RET:    begin srcA = RESP; srcB = RESP; dstE = RESP; end
      ICODE_PUSHL:  begin srcA = D_rA; srcB = RESP; dstE = RESP; end
      ICODE_POPL:   begin srcA = RESP; srcB = RESP; dstE = RESP; dstM = D_rA; end
      default: ;
    endcase
  end

  assign fwd_dst = {W_dstE, W_dstM, M_dstE, M_dstM, e_dstE};
  assign fwd_val = {W_valE, W_valM, M_valE, m_valM, e_valE};

  fwd_mux u_fwd_a (
    .src(srcA), .rf_val(rf_valA), .dst(fwd_dst), .val(fwd_val),
    .val_out(fwd_valA), .hit(hit_a)
  );

  fwd_mux u_fwd_b (
    .src(srcB), .rf_val(rf_valB), .dst(fwd_dst), .val(fwd_val),
    .val_out(fwd_valB), .hit(hit_b)
  );

  // Without forwarding, any in-flight writer of a source must stall decode.
  always_comb begin
    load_use = (E_icode == ICODE_MRMOVL || E_icode == ICODE_POPL) && E_dstM != RNONE &&
               (E_dstM == srcA || E_dstM == srcB);
    e_dstm_hit = E_dstM != RNONE && (E_dstM == srcA || E_dstM == srcB);
    hazard = FWD_EN ? load_use : (hit_a | hit_b | e_dstm_hit);
    d_valB = FWD_EN ? fwd_valB : rf_valB;
    if (D_icode == ICODE_CALL || D_icode == ICODE_JXX) d_valA = D_valP;
    else d_valA = FWD_EN ? fwd_valA : rf_valA;
  end

  always_comb begin
    e_next = '{icode: D_icode, ifun: D_ifun, valC: D_valC, valA: d_valA, valB: d_valB,
               dstE: dstE, dstM: dstM, srcA: srcA, srcB: srcB};
  end

  // Bubble outranks stall so control can squash a held instruction.
  always_ff @(posedge CLK) begin
    if (RST || E_bubble) e_reg <= NOP_BUBBLE;
    else if (!E_stall)   e_reg <= e_next;
  end

  assign E_icode = e_reg.icode;
  assign E_ifun  = e_reg.ifun;
  assign E_valC  = e_reg.valC;
  assign E_valA  = e_reg.valA;
  assign E_valB  = e_reg.valB;
  assign E_dstE  = e_reg.dstE;
  assign E_dstM  = e_reg.dstM;
  assign E_srcA  = e_reg.srcA;
  assign E_srcB  = e_reg.srcB;

endmodule
